// File: rtl/avalon_mm_host_port.sv
// avalon_mm_host_port: single-outstanding Avalon-MM host with waitrequest, optional readdatavalid and stall timeout
module avalon_mm_host_port #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int USE_READDATAVALID = 0,
    parameter int TIMEOUT = 255,
    localparam int BE_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [BE_W-1:0]   cmd_byteenable,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    output logic [BE_W-1:0]   avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, XFER, RD_WAIT} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [ADDR_W-1:0] address_n;
    logic              read_n, write_n, rsp_valid_n, rsp_error_n;
    logic [DATA_W-1:0] writedata_n, rsp_rdata_n;
    logic [BE_W-1:0]   byteenable_n;
    logic              expired;

    assign cmd_ready = (state == IDLE);
    assign expired   = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT));

    // Next-state and next-output logic; completion is tested before the timeout so it wins a tie
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        address_n    = avm_address;
        read_n       = avm_read;
        write_n      = avm_write;
        writedata_n  = avm_writedata;
        byteenable_n = avm_byteenable;
        rsp_valid_n  = 1'b0;
        rsp_rdata_n  = rsp_rdata;
        rsp_error_n  = rsp_error;
        case (state)
            IDLE: if (cmd_valid) begin
                state_n      = XFER;
                cnt_n        = '0;
                address_n    = cmd_addr;
                writedata_n  = cmd_wdata;
                byteenable_n = cmd_byteenable;
                write_n      = cmd_write;
                read_n       = ~cmd_write;
            end
            XFER: if (!avm_waitrequest) begin
                read_n  = 1'b0;
                write_n = 1'b0;
                if (avm_read && USE_READDATAVALID != 0) begin
                    state_n = RD_WAIT;
                    cnt_n   = '0;
                end else begin
                    state_n     = IDLE;
                    rsp_valid_n = 1'b1;
                    rsp_error_n = 1'b0;
                    rsp_rdata_n = avm_read ? avm_readdata : '0;
                end
            end else if (expired) begin
                state_n     = IDLE;
                read_n      = 1'b0;
                write_n     = 1'b0;
                rsp_valid_n = 1'b1;
                rsp_error_n = 1'b1;
                rsp_rdata_n = '0;
            end else begin
                cnt_n = cnt + 1'b1;
            end
            RD_WAIT: if (avm_readdatavalid) begin
                state_n     = IDLE;
                rsp_valid_n = 1'b1;
                rsp_error_n = 1'b0;
                rsp_rdata_n = avm_readdata;
            end else if (expired) begin
                state_n     = IDLE;
                rsp_valid_n = 1'b1;
                rsp_error_n = 1'b1;
                rsp_rdata_n = '0;
            end else begin
                cnt_n = cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // State, counter and all registered bus/response outputs; reset drops any in-flight transfer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            cnt            <= '0;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_error      <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            avm_address    <= address_n;
            avm_read       <= read_n;
            avm_write      <= write_n;
            avm_writedata  <= writedata_n;
            avm_byteenable <= byteenable_n;
            rsp_valid      <= rsp_valid_n;
            rsp_rdata      <= rsp_rdata_n;
            rsp_error      <= rsp_error_n;
        end
    end
endmodule

// File: tb/tb_avalon_mm_host_port.sv
// tb_avalon_mm_host_port: scoreboard bench driving a direct-data and a readdatavalid instance against a register agent
module tb_avalon_mm_host_port;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic        cv0, cv1, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_be;
    logic        rdy0, rdy1, rv0, rv1, re0, re1, r0, r1, w0, w1;
    logic [31:0] rd0, rd1, ad0, ad1, wd0, wd1;
    logic [3:0]  be0, be1;
    logic        avm_waitrequest, avm_readdatavalid;
    logic [31:0] avm_readdata;

    avalon_mm_host_port #(.USE_READDATAVALID(0), .TIMEOUT(8)) dut0 (
        .clk(clk), .resetn(resetn), .cmd_valid(cv0), .cmd_ready(rdy0), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_byteenable(cmd_be),
        .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_error(re0),
        .avm_address(ad0), .avm_read(r0), .avm_write(w0), .avm_writedata(wd0), .avm_byteenable(be0),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid)
    );

    avalon_mm_host_port #(.USE_READDATAVALID(1), .TIMEOUT(8)) dut1 (
        .clk(clk), .resetn(resetn), .cmd_valid(cv1), .cmd_ready(rdy1), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_byteenable(cmd_be),
        .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_error(re1),
        .avm_address(ad1), .avm_read(r1), .avm_write(w1), .avm_writedata(wd1), .avm_byteenable(be1),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid)
    );

    // the agent and monitor follow whichever instance is selected
    logic        sel;
    logic        a_read, a_write, r_valid, r_err;
    logic [31:0] a_address, a_wdata, r_rdata;
    logic [3:0]  a_be;
    assign a_read    = sel ? r1 : r0;
    assign a_write   = sel ? w1 : w0;
    assign a_address = sel ? ad1 : ad0;
    assign a_wdata   = sel ? wd1 : wd0;
    assign a_be      = sel ? be1 : be0;
    assign r_valid   = sel ? rv1 : rv0;
    assign r_rdata   = sel ? rd1 : rd0;
    assign r_err     = sel ? re1 : re0;

    int          ws, stall, rdv_delay, rdv_cnt, cyc;
    logic        stuck, stray;
    logic [31:0] mem [16];
    logic [31:0] rd_word;

    assign avm_waitrequest   = stuck || ((a_read || a_write) && stall < ws);
    assign avm_readdata      = sel ? rd_word : mem[a_address[5:2]];
    assign avm_readdatavalid = (rdv_cnt == 1) || stray;

    always @(posedge clk) cyc <= cyc + 1;

    // byte-enabled 32-bit register agent with programmable wait states and readdatavalid delay
    always @(posedge clk) begin
        if (!resetn) begin
            mem     <= '{default: 32'h0};
            mem[4]  <= 32'hA5A5_0001;
            stall   <= 0;
            rdv_cnt <= 0;
            rd_word <= 32'h0;
        end else begin
            stall <= ((a_read || a_write) && avm_waitrequest) ? stall + 1 : 0;
            if (a_write && !avm_waitrequest)
                for (int b = 0; b < 4; b++)
                    if (a_be[b]) mem[a_address[5:2]][8*b +: 8] <= a_wdata[8*b +: 8];
            if (a_read && !avm_waitrequest && sel) begin
                rdv_cnt <= rdv_delay;
                rd_word <= mem[a_address[5:2]];
            end else if (rdv_cnt > 0) begin
                rdv_cnt <= rdv_cnt - 1;
            end
        end
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr, wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        logic        err;
        int          lat, strb, acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0, errors = 0, strb_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // monitor: bus strobes checked against the head entry, responses popped and compared
    always @(negedge clk) begin
        if (!resetn) begin
            q.delete();
            strb_cnt = 0;
        end else begin
            if (a_read || a_write) begin
                if (q.size() == 0) begin
                    check("stray_strobe", {62'h0, a_read, a_write}, 64'h0);
                end else begin
                    strb_cnt++;
                    check("addr", 64'(a_address), 64'(q[0].addr));
                    check("dir", {62'h0, a_read, a_write}, q[0].wr ? 64'h1 : 64'h2);
                    check("be", 64'(a_be), 64'(q[0].be));
                    if (q[0].wr) check("wdata", 64'(a_wdata), 64'(q[0].wdata));
                end
            end
            if (r_valid) begin
                if (q.size() == 0) begin
                    check("stray_rsp", 64'(r_valid), 64'h0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("rdata", 64'(r_rdata), 64'(e.rdata));
                    check("err", 64'(r_err), 64'(e.err));
                    check("latency", 64'(cyc - e.acc), 64'(e.lat));
                    check("strobe_cycles", 64'(strb_cnt), 64'(e.strb));
                    strb_cnt = 0;
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] rdata, input logic err, input int lat, input int strb);
        exp_t e;
        int   n, idx;
        e.wr = wr; e.addr = addr; e.wdata = wdata; e.be = be;
        e.rdata = rdata; e.err = err; e.lat = lat; e.strb = strb; e.acc = 0;
        q.push_back(e);
        cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_be = be;
        if (sel) cv1 = 1'b1; else cv0 = 1'b1;
        n = 0;
        while (!(sel ? rdy1 : rdy0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) check("accept", 64'(sel ? rdy1 : rdy0), 64'h1);
        idx = q.size() - 1;
        if (idx >= 0) q[idx].acc = cyc;
        @(negedge clk);
        cv0 = 1'b0;
        cv1 = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) check("rsp_timeout", 64'(q.size()), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        cyc = 0; sel = 1'b0; cv0 = 1'b0; cv1 = 1'b0; cmd_write = 1'b0;
        cmd_addr = 0; cmd_wdata = 0; cmd_be = 0;
        ws = 0; rdv_delay = 0; stuck = 1'b0; stray = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("rst_ready", 64'(rdy0), 64'h1);
        check("rst_ready1", 64'(rdy1), 64'h1);
        check("rst_strobes", {62'h0, r0, w0}, 64'h0);
        check("rst_rsp_valid", 64'(rv0), 64'h0);
        check("rst_address", 64'(ad0), 64'h0);
        check("rst_rdata", 64'(rd0), 64'h0);

        ws = 3;
        issue(1'b0, 32'h10, 32'h0, 4'hF, 32'hA5A5_0001, 1'b0, 5, 4);
        wait_rsp();
        ws = 0;
        issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 2, 1);
        wait_rsp();
        issue(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 2, 1);
        wait_rsp();
        repeat (3) @(negedge clk);
        check("rdata_hold", 64'(rd0), 64'hDEAD_BEEF);
        check("err_hold", 64'(re0), 64'h0);

        issue(1'b1, 32'h20, 32'h1122_3344, 4'b0101, 32'h0, 1'b0, 2, 1);
        issue(1'b0, 32'h20, 32'h0, 4'hF, 32'h0022_0044, 1'b0, 2, 1);
        wait_rsp();

        ws = 8;
        issue(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 10, 9);
        wait_rsp();
        ws = 0;
        stuck = 1'b1;
        issue(1'b1, 32'h30, 32'h5555_AAAA, 4'hF, 32'h0, 1'b1, 10, 9);
        wait_rsp();
        stuck = 1'b0;
        repeat (2) @(negedge clk);
        check("err_hold_timeout", 64'(re0), 64'h1);
        issue(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 2, 1);
        wait_rsp();

        sel = 1'b1;
        rdv_delay = 4;
        issue(1'b0, 32'h20, 32'h0, 4'hF, 32'h0022_0044, 1'b0, 6, 1);
        wait_rsp();
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stray_rdv", 64'(rv1), 64'h0);
        end
        issue(1'b1, 32'h24, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 2, 1);
        wait_rsp();
        rdv_delay = 20;
        issue(1'b0, 32'h10, 32'h0, 4'hF, 32'h0, 1'b1, 11, 1);
        wait_rsp();
        repeat (15) begin
            @(negedge clk);
            check("late_rdv", 64'(rv1), 64'h0);
        end
        ws = 2;
        rdv_delay = 2;
        issue(1'b0, 32'h20, 32'h0, 4'hF, 32'h0022_0044, 1'b0, 6, 3);
        wait_rsp();
        ws = 0;

        sel = 1'b0;
        stuck = 1'b1;
        issue(1'b0, 32'h50, 32'h0, 4'hF, 32'h0, 1'b0, 0, 0);
        @(negedge clk);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("async_rst_read", 64'(r0), 64'h0);
        check("async_rst_write", 64'(w0), 64'h0);
        check("async_rst_rsp", 64'(rv0), 64'h0);
        check("async_rst_ready", 64'(rdy0), 64'h1);
        stuck = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("post_rst_rsp", 64'(rv0), 64'h0);
        end
        issue(1'b1, 32'h40, 32'h0BAD_F00D, 4'b1100, 32'h0, 1'b0, 2, 1);
        wait_rsp();
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/avalon_mm_host_port.md
Name: avalon_mm_host_port

Overview:
- Single-outstanding Avalon-MM host (master) port.
- Turns simple command/response requests from user logic into Avalon-MM read and write transfers.
- Targets memory-mapped agents such as our 32-bit byte-enabled register peripherals.
- Handles waitrequest stalls, optional readdatavalid, and a transfer timeout that reports an error instead of hanging.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits; multiple of 8; byteenable width BE_W = DATA_W/8
USE_READDATAVALID, 0, 0: read data sampled in the waitrequest-low cycle; 1: read data sampled on readdatavalid
TIMEOUT, 255, max cycles a transfer may stall before abort; 0 disables timeout

Ports:
clk  input  1  clock
resetn  input  1  reset, asynchronous, active-low
cmd_valid  input  1  command request
cmd_ready  output  1  block can accept a command
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_W  byte address
cmd_wdata  input  DATA_W  write data
cmd_byteenable  input  BE_W  byte lanes to write
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  DATA_W  read data; 0 for writes and errors
rsp_error  output  1  transfer aborted by timeout
avm_address  output  ADDR_W  Avalon address
avm_read  output  1  Avalon read
avm_write  output  1  Avalon write
avm_writedata  output  DATA_W  Avalon write data
avm_byteenable  output  BE_W  Avalon byte enables
avm_waitrequest  input  1  agent stall
avm_readdata  input  DATA_W  agent read data
avm_readdatavalid  input  1  agent read data valid; ignored when USE_READDATAVALID=0

Behaviour:
- Reset (resetn low, asynchronous, any state): state IDLE, timeout counter 0, all outputs 0 except cmd_ready=1. Any in-flight transfer is dropped; no response is issued.
- All avm_* and rsp_* outputs are registered. cmd_ready = (state == IDLE).
- States: IDLE, XFER, RD_WAIT.
- IDLE:
  - Command accepted when cmd_valid & cmd_ready.
  - Next edge: latch address, writedata and byteenable onto avm_*, assert avm_write (cmd_write=1) or avm_read (cmd_write=0), clear the counter, go to XFER.
  - Read byteenable is driven from cmd_byteenable.
- XFER:
  - avm_* held stable while avm_waitrequest=1.
  - The transfer completes in the cycle where the strobe is high and avm_waitrequest=0.
  - Write completion: next edge deasserts avm_write, pulses rsp_valid=1 with rsp_error=0 and rsp_rdata=0, returns to IDLE.
  - Read completion with USE_READDATAVALID=0: capture avm_readdata into rsp_rdata, deassert avm_read, pulse rsp_valid, return to IDLE.
  - Read completion with USE_READDATAVALID=1: deassert avm_read, clear the counter, go to RD_WAIT.
- RD_WAIT: on avm_readdatavalid=1, capture avm_readdata, pulse rsp_valid, return to IDLE.
- Minimum latency (accept edge to rsp_valid): 2 cycles with no wait states and USE_READDATAVALID=0; each waitrequest cycle adds 1.
- Timeout (TIMEOUT>0):
  - Counter increments every cycle in XFER or RD_WAIT without completion.
  - When the counter reaches TIMEOUT, next edge deasserts strobes, pulses rsp_valid=1 with rsp_error=1 and rsp_rdata=0, and returns to IDLE.
  - If completion and counter==TIMEOUT occur in the same cycle, completion wins.
- avm_readdatavalid outside RD_WAIT is ignored, including late data after a timeout.
- rsp_valid is high exactly 1 cycle per accepted command, with no backpressure. rsp_rdata and rsp_error hold until the next response.
- cmd_ready rises in the same cycle as rsp_valid, so back-to-back commands are allowed; throughput is 1 transfer per 2 cycles at best.
- Commands presented while cmd_ready=0 are not accepted; user logic must hold cmd_valid.

Test Plan:
- Write, addr 0x10, data 0xDEADBEEF, be 4'b1111, waitrequest=0 → avm_write high exactly 1 cycle with those values; rsp_valid 2 cycles after accept; rsp_error=0.
- Read, addr 0x10, waitrequest held 3 cycles, readdata 0xA5A5_0001 → avm_read and address stable 4 cycles; rsp_rdata=0xA5A50001 on a single rsp_valid pulse.
- Write with be 4'b0101 then read-back against a byte-enabled 32-bit register agent preloaded with 0 and data 0x11223344 → read returns 0x00220044.
- USE_READDATAVALID=1: readdatavalid 5 cycles after acceptance → data captured; a stray readdatavalid while IDLE produces no rsp_valid.
- TIMEOUT=8, waitrequest stuck high → strobe drops and rsp_valid=1, rsp_error=1, rsp_rdata=0 after 8 stall cycles; next command is accepted normally.
- resetn pulsed low mid-XFER → avm_read, avm_write and rsp_valid go 0 immediately, cmd_ready=1; no response emitted after release.
